// File: rtl/hash_table_pkg.sv
// Shared hash-table types: command encoding carried with every task.
package hash_table;
  typedef enum logic [1:0] {
    HT_SEARCH = 2'd0,
    HT_INSERT = 2'd1,
    HT_DELETE = 2'd2,
    HT_NOP    = 2'd3
  } ht_cmd_t;
endpackage

// File: rtl/ht_task_if.sv
// Valid/ready task channel: key, value and command toward or from the hash table.
interface ht_task_if
  import hash_table::*;
#(
  parameter int KEY_WIDTH   = 32,
  parameter int VALUE_WIDTH = 16
) ();
  logic [KEY_WIDTH-1:0]   key;
  logic [VALUE_WIDTH-1:0] value;
  ht_cmd_t                cmd;
  logic                   valid;
  logic                   ready;

  modport master (output key, value, cmd, valid, input ready);
  modport slave  (input key, value, cmd, valid, output ready);
endinterface

// File: rtl/ht_task_fifo_ram.sv
// Simple dual-port storage with a registered read; no reset on contents.
module ht_task_fifo_ram #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);
  logic [WIDTH-1:0] mem_q [2**ADDR_W];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/ht_task_queue.sv
// Task FIFO in front of the hash table with an in-flight cap and an underflow flag.
module ht_task_queue
  import hash_table::*;
#(
  parameter int KEY_WIDTH    = 32,
  parameter int VALUE_WIDTH  = 16,
  parameter int DEPTH_LOG2   = 4,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  ht_task_if.slave              ht_task_in,
  ht_task_if.master             ht_task_out,
  input  logic                  res_done_i,
  output logic [DEPTH_LOG2:0]   used_words_o,
  output logic [7:0]            inflight_o,
  output logic                  underflow_err_o
);
  localparam int CMD_W = $bits(ht_cmd_t);
  localparam int DW    = KEY_WIDTH + VALUE_WIDTH + CMD_W;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(2**DEPTH_LOG2);

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   used_q, used_d;
  logic [7:0]            infl_q, infl_d;
  logic                  err_q, err_d, rdy_q, rdy_d, fwd_q, fwd_d;
  logic [DW-1:0]         fwd_data_q, wdata, ram_rdata, rdata;
  logic                  push, pop, out_valid;

  assign push      = ht_task_in.valid & ht_task_in.ready;
  assign out_valid = !rst_i && (used_q != '0) && (infl_q < 8'(MAX_INFLIGHT));
  assign pop       = out_valid & ht_task_out.ready;
  assign wdata     = {ht_task_in.cmd, ht_task_in.value, ht_task_in.key};

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    used_d   = used_q;
    case ({push, pop})
      2'b10:   used_d = used_q + 1'b1;
      2'b01:   used_d = used_q - 1'b1;
      default: used_d = used_q;
    endcase
    rdy_d = (used_d != FULL_CNT);
    // The RAM returns stale data when the write and read address collide on one edge.
    fwd_d = push && (wr_ptr_q == rd_ptr_d);
    infl_d = infl_q;
    err_d  = err_q;
    case ({pop, res_done_i})
      2'b10: infl_d = infl_q + 8'd1;
      2'b01: begin
        if (infl_q == 8'd0) err_d = 1'b1;
        else                infl_d = infl_q - 8'd1;
      end
      default: infl_d = infl_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      used_q     <= '0;
      infl_q     <= '0;
      err_q      <= 1'b0;
      rdy_q      <= 1'b1;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      used_q     <= used_d;
      infl_q     <= infl_d;
      err_q      <= err_d;
      rdy_q      <= rdy_d;
      fwd_q      <= fwd_d;
      fwd_data_q <= wdata;
    end
  end

  ht_task_fifo_ram #(.WIDTH(DW), .ADDR_W(DEPTH_LOG2)) u_ram (
    .clk_i   (clk_i),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata),
    .raddr_i (rd_ptr_d),
    .rdata_o (ram_rdata)
  );

  assign rdata             = fwd_q ? fwd_data_q : ram_rdata;
  assign ht_task_in.ready  = rdy_q && !rst_i;
  assign ht_task_out.valid = out_valid;
  assign ht_task_out.key   = rdata[KEY_WIDTH-1:0];
  assign ht_task_out.value = rdata[KEY_WIDTH +: VALUE_WIDTH];
  assign ht_task_out.cmd   = ht_cmd_t'(rdata[DW-1 -: CMD_W]);
  assign used_words_o      = used_q;
  assign inflight_o        = infl_q;
  assign underflow_err_o   = err_q;
endmodule

// File: doc/ht_task_queue.md
HT_TASK_QUEUE -- requirements
Module: ht_task_queue

Interface
REQ-001 SHALL have parameter KEY_WIDTH, default 32, task key width.
REQ-002 SHALL have parameter VALUE_WIDTH, default 16, task value width.
REQ-003 SHALL have parameter DEPTH_LOG2, default 4, queue depth = 2**DEPTH_LOG2 entries.
REQ-004 SHALL have parameter MAX_INFLIGHT, default 8, range 1..255, cap on tasks issued to the hash table without a returned result.
REQ-005 SHALL have port clk_i, input, 1, the single clock.
REQ-006 SHALL have port rst_i, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port ht_task_in, ht_task_if.slave, key/value/cmd/valid/ready, tasks from the user.
REQ-008 SHALL have port ht_task_out, ht_task_if.master, key/value/cmd/valid/ready, tasks to hash_table_top.
REQ-009 SHALL have port res_done_i, input, 1, one-cycle pulse per result accepted on ht_res_out (valid & ready).
REQ-010 SHALL have port used_words_o, output, DEPTH_LOG2+1, entries currently stored.
REQ-011 SHALL have port inflight_o, output, 8, tasks issued and not yet completed.
REQ-012 SHALL have port underflow_err_o, output, 1, sticky: res_done_i seen with inflight_o == 0.

Function
REQ-013 SHALL store key, value and cmd of every input handshake (valid & ready) in FIFO order, with no loss, duplication or reordering.
REQ-014 SHALL drive ht_task_in.ready = !full, registered; it SHALL NOT depend combinationally on ht_task_out.ready.
REQ-015 SHALL present a task accepted at cycle N on ht_task_out no earlier than cycle N+1, including when the queue is empty (no bypass path).
REQ-016 SHALL drive ht_task_out.valid = !empty AND (inflight_o < MAX_INFLIGHT).
REQ-017 SHALL hold ht_task_out key/value/cmd stable while valid is high and ready is low.
REQ-018 SHALL advance the read pointer only on ht_task_out.valid & ready.
REQ-019 SHALL leave used_words_o unchanged on simultaneous push and pop, +1 on push only, -1 on pop only.
REQ-020 SHALL keep pointers DEPTH_LOG2 bits wide with natural wrap-around; full = used_words_o == 2**DEPTH_LOG2, empty = used_words_o == 0.
REQ-021 SHALL accept a push at full only on a cycle after a pop has cleared full (registered ready), never over-writing.
REQ-022 SHALL increment inflight_o on output handshake and decrement on res_done_i; both in the same cycle leaves it unchanged.
REQ-023 SHALL, on res_done_i with inflight_o == 0 and no simultaneous output handshake, hold inflight_o at 0 and set underflow_err_o.
REQ-024 SHALL, when res_done_i and an output handshake coincide with inflight_o == MAX_INFLIGHT, never let inflight_o exceed MAX_INFLIGHT.

Reset
REQ-025 SHALL, while rst_i is high at a clock edge, clear pointers, used_words_o, inflight_o and underflow_err_o to 0 and drive ht_task_out.valid = 0, ht_task_in.ready = 0.
REQ-026 SHALL drive ht_task_in.ready = 1 on the first cycle after rst_i deasserts.
REQ-027 SHALL discard all queued tasks on reset mid-operation; storage RAM contents need no reset.

Structure
REQ-028 SHALL take ht_cmd_t and the ht_task_if definition from package hash_table; no new package types.
REQ-029 SHALL implement storage as one sub-module ht_task_fifo_ram (simple dual-port, registered read, write-before-read not required).
REQ-030 SHALL keep inflight limiting and error flag in ht_task_queue itself.

Verification
REQ-031 SHALL cover: reset, push keys 1..16 with ready_out=0 -> used_words_o=16, in.ready=0 after 16th; 17th held by user, not lost.
REQ-032 SHALL cover: MAX_INFLIGHT=2, 5 tasks queued, out.ready=1, no res_done_i -> exactly 2 issued, out.valid=0, inflight_o=2; one res_done_i pulse -> third issued next cycle.
REQ-033 SHALL cover: empty queue, push key=0xA5 at cycle N with out.ready=1 -> out.valid first high at N+1 with key 0xA5.
REQ-034 SHALL cover: continuous push and pop at DEPTH_LOG2=2 for 40 tasks -> used_words_o constant, order preserved across pointer wrap.
REQ-035 SHALL cover: res_done_i with inflight_o=0 -> inflight_o stays 0, underflow_err_o=1 until rst_i.
REQ-036 SHALL cover: rst_i asserted with 3 queued and 2 in flight -> next cycle used_words_o=0, inflight_o=0, out.valid=0.
